wb8_arbiter: RTL and testbench
==============================

Name: wb8_arbiter

Overview:
Round-robin arbiter that shares one 8-bit Wishbone slave port between NUM_MASTERS requesters. The slave is typically the GPIO peripheral: 1-bit address, registered ack one cycle after stb. The arbiter sits between the CPU bus and auxiliary masters (e.g. DMA, debug port) and the 8-bit peripheral. It serialises classic single-beat transactions and never issues a duplicate strobe.

Parameters:
NUM_MASTERS, 2, number of requesters (2..8).
ADR_WIDTH, 1, slave address width in bits.
TIMEOUT_CYCLES, 15, BUSY cycles without ack before abort (only with WB8_ARB_TIMEOUT_EN).

Ports:
I_wb_clk  in  1  system clock; all state updates on rising edge.
I_reset  in  1  synchronous, active-high reset.
I_m_adr  in  NUM_MASTERS*ADR_WIDTH  per-master address, master i at slice i.
I_m_dat  in  NUM_MASTERS*8  per-master write data.
I_m_stb  in  NUM_MASTERS  per-master request strobe, held until own ack.
I_m_we  in  NUM_MASTERS  per-master write enable.
O_m_ack  out  NUM_MASTERS  per-master ack, one-hot or zero.
O_m_dat  out  8  read data broadcast to all masters; valid with ack.
O_slv_adr  out  ADR_WIDTH  latched address to slave.
O_slv_dat  out  8  latched write data to slave.
O_slv_stb  out  1  slave strobe.
O_slv_we  out  1  latched write enable.
I_slv_ack  in  1  slave ack.
I_slv_dat  in  8  slave read data.
O_grant  out  NUM_MASTERS  one-hot current grant, 0 when idle.
O_timeout  out  1  one-cycle abort pulse.

Behaviour:
- Clock and reset: one clock, I_wb_clk. Reset is synchronous and active-high on I_reset.
- States: IDLE, BUSY.
- Reset values: state=IDLE, O_grant=0, O_slv_stb=0, O_m_ack=0, O_timeout=0, O_slv_adr/dat/we=0, rr pointer=0 (master 0 highest priority).
- IDLE, at least one I_m_stb set:
  - Pick the first requester searching from the rr pointer upward, wrapping modulo NUM_MASTERS.
  - Register its adr/dat/we into O_slv_*, set O_grant one-hot, go to BUSY.
  - Set rr pointer = winner+1 mod NUM_MASTERS.
- IDLE, no request: stay in IDLE; pointer unchanged.
- BUSY outputs: O_slv_stb = busy & ~I_slv_ack (combinational mask). Strobe drops in the ack cycle, so a registered-ack slave sees exactly one strobe per transaction.
- Ack routing: O_m_ack[g] = I_slv_ack & O_grant[g] & I_m_stb[g]. O_m_dat = I_slv_dat combinationally; O_m_dat is don't-care when no ack.
- On I_slv_ack in BUSY: next state IDLE, O_grant cleared.
- Latency: request sampled at edge t; O_slv_stb high cycle t+1; GPIO-type slave acks at t+2; O_m_ack at t+2; IDLE at t+3. Minimum 3 cycles per transaction.
- Back-to-back: a master must drop stb the cycle after its ack. A stb still high in IDLE is treated as a new request.
- Master drops stb while granted (protocol violation): the slave transaction completes anyway; the ack is suppressed by the gating term above.
- Simultaneous requests: exactly one grant. Every continuously requesting master is served within NUM_MASTERS transactions.
- Reset mid-BUSY: next cycle IDLE, stb=0, no ack to any master, pointer=0.
- I_slv_ack while IDLE: ignored; no O_m_ack.

Optional Feature:
WB8_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT_CYCLES: O_slv_stb low, O_m_ack[g] pulsed one cycle with O_m_dat=8'hFF, O_timeout=1 for that cycle, next state IDLE.
  - A real ack arriving in the same cycle wins: normal completion, no O_timeout.
- Undefined: no counter; BUSY waits indefinitely; O_timeout tied 0.

Decomposition:
- Package wb8_arb_pkg: state encoding constants (ST_IDLE, ST_BUSY) and the abort data constant (8'hFF).
- Sub-module wb8_rr_picker: combinational round-robin select from request vector plus pointer, producing a one-hot winner and a valid flag.

Test Plan:
- Write: m0 writes adr=1, dat=8'hA5 -> O_slv_stb high exactly one cycle (t+1), O_m_ack[0] at t+2, GPIO direction=8'hA5, O_m_ack[1] never set.
- Read: m1 reads adr=1 after the write above -> O_m_ack[1] one cycle with O_m_dat=8'hA5.
- Fairness: m0 and m1 assert stb simultaneously after reset and re-request immediately after each ack -> grant sequence 0,1,0,1 over 4 transactions; no master waits more than one transaction.
- Reset mid-operation: I_reset asserted in first BUSY cycle -> next cycle O_slv_stb=0, O_grant=0, no ack; after release both request -> m0 granted first.
- Violation: m0 drops stb while BUSY -> slave still acks, O_m_ack[0]=0, arbiter returns to IDLE.
- Timeout: I_slv_ack tied 0, TIMEOUT_CYCLES=15, macro defined -> O_m_ack[0] with 8'hFF and O_timeout pulse in the 15th BUSY cycle. Macro undefined -> no ack within 100 cycles, O_timeout=0.

Source files
------------

// File: rtl/wb8_arb_pkg.sv
// rtl/wb8_arb_pkg.sv - shared state encoding and constants for the 8-bit Wishbone arbiter
package wb8_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Read data returned to the granted master when a stalled transfer is aborted
  localparam logic [7:0] ABORT_DAT = 8'hFF;

endpackage

// File: rtl/wb8_rr_picker.sv
// rtl/wb8_rr_picker.sv - combinational round-robin select: first request at or above ptr, wrapping
module wb8_rr_picker #(
  parameter int NUM_MASTERS = 2,
  parameter int PTR_W       = 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [PTR_W-1:0]       ptr,
  output logic [NUM_MASTERS-1:0] winner,
  output logic [PTR_W-1:0]       winner_idx,
  output logic                   valid
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] sel;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    valid      = 1'b0;
    sum        = '0;
    sel        = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      // ptr + k folded back into 0..NUM_MASTERS-1; one spare bit holds the carry
      sum = {1'b0, ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_MASTERS)) begin
        sum = sum - (PTR_W+1)'(NUM_MASTERS);
      end
      sel = sum[PTR_W-1:0];
      if (!valid && req[sel]) begin
        valid       = 1'b1;
        winner[sel] = 1'b1;
        winner_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/wb8_arbiter.sv
// rtl/wb8_arbiter.sv - round-robin arbiter sharing one 8-bit Wishbone slave between masters
// Optional stall abort enabled by defining WB8_ARB_TIMEOUT_EN.
module wb8_arbiter
  import wb8_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int ADR_WIDTH      = 1,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                           I_wb_clk,
  input  logic                           I_reset,
  input  logic [NUM_MASTERS*ADR_WIDTH-1:0] I_m_adr,
  input  logic [NUM_MASTERS*8-1:0]       I_m_dat,
  input  logic [NUM_MASTERS-1:0]         I_m_stb,
  input  logic [NUM_MASTERS-1:0]         I_m_we,
  output logic [NUM_MASTERS-1:0]         O_m_ack,
  output logic [7:0]                     O_m_dat,
  output logic [ADR_WIDTH-1:0]           O_slv_adr,
  output logic [7:0]                     O_slv_dat,
  output logic                           O_slv_stb,
  output logic                           O_slv_we,
  input  logic                           I_slv_ack,
  input  logic [7:0]                     I_slv_dat,
  output logic [NUM_MASTERS-1:0]         O_grant,
  output logic                           O_timeout
);

  localparam int PTR_W = $clog2(NUM_MASTERS);

  state_t                 state_q;
  state_t                 state_d;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [PTR_W-1:0]       rr_ptr_q;
  logic [NUM_MASTERS-1:0] pick_onehot;
  logic [PTR_W-1:0]       pick_idx;
  logic                   pick_valid;
  logic                   busy;
  logic                   tmo_fire;
  logic                   done;

  wb8_rr_picker #(
    .NUM_MASTERS(NUM_MASTERS),
    .PTR_W      (PTR_W)
  ) u_picker (
    .req       (I_m_stb),
    .ptr       (rr_ptr_q),
    .winner    (pick_onehot),
    .winner_idx(pick_idx),
    .valid     (pick_valid)
  );

  assign busy = (state_q == ST_BUSY);
  assign done = busy & (I_slv_ack | tmo_fire);

`ifdef WB8_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_q;

  // Counter holds the number of ack-less BUSY cycles already elapsed, so the
  // abort lands in BUSY cycle TIMEOUT_CYCLES; a real ack in that cycle wins.
  assign tmo_fire = busy & ~I_slv_ack & (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge I_wb_clk) begin
    if (I_reset || !busy) begin
      tmo_cnt_q <= '0;
    end else if (!I_slv_ack) begin
      tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
    end
  end
`else
  assign tmo_fire = 1'b0;
`endif

  always_ff @(posedge I_wb_clk) begin
    if (I_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pick_valid) state_d = ST_BUSY;
      ST_BUSY: if (I_slv_ack || tmo_fire) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobe is masked in the ack cycle so a registered-ack slave sees one strobe
  always_comb begin
    O_slv_stb = busy & ~I_slv_ack & ~tmo_fire;
    O_m_ack   = (done ? grant_q : '0) & I_m_stb;
    O_m_dat   = tmo_fire ? ABORT_DAT : I_slv_dat;
    O_timeout = tmo_fire;
  end

  always_ff @(posedge I_wb_clk) begin
    if (I_reset) begin
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      O_slv_adr <= '0;
      O_slv_dat <= '0;
      O_slv_we  <= 1'b0;
    end else if (state_q == ST_IDLE && pick_valid) begin
      grant_q   <= pick_onehot;
      O_slv_adr <= I_m_adr[int'(pick_idx)*ADR_WIDTH +: ADR_WIDTH];
      O_slv_dat <= I_m_dat[int'(pick_idx)*8 +: 8];
      O_slv_we  <= I_m_we[pick_idx];
      rr_ptr_q  <= (pick_idx == PTR_W'(NUM_MASTERS - 1)) ? '0 : pick_idx + PTR_W'(1);
    end else if (done) begin
      grant_q <= '0;
    end
  end

  assign O_grant = grant_q;

endmodule

// File: tb/tb_wb8_arbiter.sv
// tb/tb_wb8_arbiter.sv - self-checking bench for wb8_arbiter with a registered-ack GPIO slave model
module tb_wb8_arbiter;

  localparam int NM = 2;
  localparam int AW = 1;

  logic           I_wb_clk = 1'b0;
  logic           I_reset  = 1'b1;
  logic [NM*AW-1:0] I_m_adr = '0;
  logic [NM*8-1:0]  I_m_dat = '0;
  logic [NM-1:0]  I_m_stb  = '0;
  logic [NM-1:0]  I_m_we   = '0;
  logic [NM-1:0]  O_m_ack;
  logic [7:0]     O_m_dat;
  logic [AW-1:0]  O_slv_adr;
  logic [7:0]     O_slv_dat;
  logic           O_slv_stb;
  logic           O_slv_we;
  logic           I_slv_ack;
  logic [7:0]     I_slv_dat;
  logic [NM-1:0]  O_grant;
  logic           O_timeout;

  wb8_arbiter #(
    .NUM_MASTERS   (NM),
    .ADR_WIDTH     (AW),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .I_wb_clk (I_wb_clk),
    .I_reset  (I_reset),
    .I_m_adr  (I_m_adr),
    .I_m_dat  (I_m_dat),
    .I_m_stb  (I_m_stb),
    .I_m_we   (I_m_we),
    .O_m_ack  (O_m_ack),
    .O_m_dat  (O_m_dat),
    .O_slv_adr(O_slv_adr),
    .O_slv_dat(O_slv_dat),
    .O_slv_stb(O_slv_stb),
    .O_slv_we (O_slv_we),
    .I_slv_ack(I_slv_ack),
    .I_slv_dat(I_slv_dat),
    .O_grant  (O_grant),
    .O_timeout(O_timeout)
  );

  always #5 I_wb_clk = ~I_wb_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // GPIO-style slave: ack registered one cycle after strobe; ack_mode 0 normal, 1 never, 2 forced
  int         ack_mode = 0;
  logic       mem_clr  = 1'b1;
  logic       ack_q    = 1'b0;
  logic [7:0] slv_mem[2];

  always @(posedge I_wb_clk) begin
    if (mem_clr) begin
      slv_mem[0] <= 8'h00;
      slv_mem[1] <= 8'h00;
    end else if (O_slv_stb && O_slv_we) begin
      slv_mem[O_slv_adr] <= O_slv_dat;
    end
    ack_q <= O_slv_stb;
  end

  assign I_slv_ack = (ack_mode == 2) ? 1'b1 : (ack_mode == 1) ? 1'b0 : ack_q;
  assign I_slv_dat = slv_mem[O_slv_adr];

  typedef struct {
    logic [NM-1:0] ack;
    logic          chk;
    logic [7:0]    dat;
  } exp_t;

  typedef struct {
    int         m;
    logic       we;
    logic       adr;
    logic [7:0] dat;
    logic [7:0] rd;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int m, input logic stb, input logic we, input logic adr,
                         input logic [7:0] dat);
    I_m_stb[m]         = stb;
    I_m_we[m]          = we;
    I_m_adr[m]         = adr;
    I_m_dat[m*8 +: 8]  = dat;
  endtask

  function automatic logic [NM-1:0] onehot(input int m);
    logic [NM-1:0] v;
    v    = '0;
    v[m] = 1'b1;
    return v;
  endfunction

  // Every ack must match the head of the scoreboard; grant never has two bits set
  always @(negedge I_wb_clk) begin
    exp_t e;
    check("grant_onehot", 32'($countones(O_grant) <= 1), 32'd1);
    if (|O_m_ack) begin
      if (sb.size() == 0) begin
        check("unexp_ack", 32'(O_m_ack), 32'd0);
      end else begin
        e = sb.pop_front();
        check("ack_route", 32'(O_m_ack), 32'(e.ack));
        if (e.chk) check("ack_data", 32'(O_m_dat), 32'(e.dat));
      end
    end
  end

  // Called just after a rising edge; request is sampled on the next edge
  task automatic run_txn(input int idx, input vec_t v);
    int stb_cnt;
    int stb_first;
    int ack_cyc;
    stb_cnt   = 0;
    stb_first = -1;
    ack_cyc   = -1;
    sb.push_back('{ack: onehot(v.m), chk: !v.we, dat: v.rd});
    set_req(v.m, 1'b1, v.we, v.adr, v.dat);
    for (int c = 1; c <= 8 && ack_cyc < 0; c++) begin
      @(negedge I_wb_clk);
      if (O_slv_stb) begin
        stb_cnt++;
        if (stb_first < 0) stb_first = c;
      end
      if (O_m_ack[v.m]) ack_cyc = c;
    end
    check($sformatf("v%0d_stb_cyc", idx), 32'(stb_first), 32'd2);
    check($sformatf("v%0d_stb_cnt", idx), 32'(stb_cnt), 32'd1);
    check($sformatf("v%0d_ack_cyc", idx), 32'(ack_cyc), 32'd3);
    @(posedge I_wb_clk);
    #1;
    set_req(v.m, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    int acks;
    int last_ack;
    int stb_cnt;
    int ack_c;
    int tmo_c;
    int tmo_n;
    logic stb_at_abort;

    vecs[0] = '{0, 1'b1, 1'b1, 8'hA5, 8'h00};
    vecs[1] = '{1, 1'b0, 1'b1, 8'h00, 8'hA5};
    vecs[2] = '{1, 1'b1, 1'b0, 8'h3C, 8'h00};
    vecs[3] = '{0, 1'b0, 1'b0, 8'h00, 8'h3C};
    vecs[4] = '{0, 1'b0, 1'b1, 8'h00, 8'hA5};
    vecs[5] = '{1, 1'b1, 1'b1, 8'h00, 8'h00};
    vecs[6] = '{0, 1'b0, 1'b1, 8'h00, 8'h00};
    vecs[7] = '{0, 1'b1, 1'b0, 8'hFF, 8'h00};
    vecs[8] = '{1, 1'b0, 1'b0, 8'h00, 8'hFF};

    repeat (3) @(posedge I_wb_clk);
    #1;
    I_reset = 1'b0;
    mem_clr = 1'b0;
    @(negedge I_wb_clk);
    check("rst_grant", 32'(O_grant), 32'd0);
    check("rst_stb", 32'(O_slv_stb), 32'd0);
    check("rst_ack", 32'(O_m_ack), 32'd0);
    check("rst_timeout", 32'(O_timeout), 32'd0);
    check("rst_slv_adr", 32'(O_slv_adr), 32'd0);
    check("rst_slv_dat", 32'(O_slv_dat), 32'd0);
    check("rst_slv_we", 32'(O_slv_we), 32'd0);

    for (int i = 0; i < 9; i++) begin
      @(posedge I_wb_clk);
      #1;
      run_txn(i, vecs[i]);
      if (i == 0) check("gpio_dir", 32'(slv_mem[1]), 32'hA5);
    end

    // Fairness: both request from reset and keep requesting -> 0,1,0,1 at 3-cycle spacing
    @(posedge I_wb_clk);
    #1;
    I_reset = 1'b1;
    @(posedge I_wb_clk);
    #1;
    I_reset = 1'b0;
    for (int k = 0; k < 4; k++) sb.push_back('{ack: onehot(k % 2), chk: 1'b1, dat: 8'h00});
    set_req(0, 1'b1, 1'b0, 1'b1, 8'h00);
    set_req(1, 1'b1, 1'b0, 1'b1, 8'h00);
    acks     = 0;
    last_ack = -1;
    for (int c = 1; c <= 20 && acks < 4; c++) begin
      @(negedge I_wb_clk);
      if (|O_m_ack) begin
        acks++;
        last_ack = c;
      end
    end
    check("fair_acks", 32'(acks), 32'd4);
    check("fair_span", 32'(last_ack), 32'd12);
    @(posedge I_wb_clk);
    #1;
    set_req(0, 1'b0, 1'b0, 1'b0, 8'h00);
    set_req(1, 1'b0, 1'b0, 1'b0, 8'h00);

    // Slave ack while idle must not reach any master
    @(posedge I_wb_clk);
    #1;
    ack_mode = 2;
    for (int c = 0; c < 3; c++) begin
      @(negedge I_wb_clk);
      check("idle_ack_ignored", 32'(O_m_ack), 32'd0);
      check("idle_ack_grant", 32'(O_grant), 32'd0);
    end
    @(posedge I_wb_clk);
    #1;
    ack_mode = 0;

    // Reset in the first BUSY cycle, then both request: pointer back to master 0
    @(posedge I_wb_clk);
    #1;
    set_req(0, 1'b1, 1'b1, 1'b0, 8'h5A);
    @(posedge I_wb_clk);
    #1;
    I_reset = 1'b1;
    set_req(1, 1'b1, 1'b0, 1'b1, 8'h00);
    sb.push_back('{ack: onehot(0), chk: 1'b0, dat: 8'h00});
    sb.push_back('{ack: onehot(1), chk: 1'b1, dat: 8'h00});
    @(negedge I_wb_clk);
    check("rstb_busy_stb", 32'(O_slv_stb), 32'd1);
    @(posedge I_wb_clk);
    #1;
    I_reset = 1'b0;
    @(negedge I_wb_clk);
    check("rstb_stb", 32'(O_slv_stb), 32'd0);
    check("rstb_grant", 32'(O_grant), 32'd0);
    check("rstb_ack", 32'(O_m_ack), 32'd0);
    @(negedge I_wb_clk);
    check("rstb_first_grant", 32'(O_grant), 32'(onehot(0)));
    acks = 0;
    for (int c = 1; c <= 12 && acks < 2; c++) begin
      @(negedge I_wb_clk);
      if (|O_m_ack) acks++;
    end
    check("rstb_acks", 32'(acks), 32'd2);
    @(posedge I_wb_clk);
    #1;
    set_req(0, 1'b0, 1'b0, 1'b0, 8'h00);
    set_req(1, 1'b0, 1'b0, 1'b0, 8'h00);

    // Protocol violation: m0 drops strobe while granted
    @(posedge I_wb_clk);
    #1;
    set_req(0, 1'b1, 1'b0, 1'b1, 8'h00);
    @(posedge I_wb_clk);
    #1;
    set_req(0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge I_wb_clk);
    check("viol_stb_held", 32'(O_slv_stb), 32'd1);
    check("viol_grant", 32'(O_grant), 32'(onehot(0)));
    @(negedge I_wb_clk);
    check("viol_slv_ack", 32'(I_slv_ack), 32'd1);
    check("viol_no_ack", 32'(O_m_ack), 32'd0);
    @(negedge I_wb_clk);
    check("viol_idle_grant", 32'(O_grant), 32'd0);
    check("viol_idle_stb", 32'(O_slv_stb), 32'd0);

    // Stalled slave
    @(posedge I_wb_clk);
    #1;
    ack_mode = 1;
    set_req(0, 1'b1, 1'b1, 1'b0, 8'h77);
    stb_cnt      = 0;
    ack_c        = -1;
    tmo_c        = -1;
    tmo_n        = 0;
    stb_at_abort = 1'b1;
`ifdef WB8_ARB_TIMEOUT_EN
    sb.push_back('{ack: onehot(0), chk: 1'b1, dat: 8'hFF});
    for (int c = 1; c <= 40 && ack_c < 0; c++) begin
      @(negedge I_wb_clk);
      if (O_slv_stb) stb_cnt++;
      if (O_timeout && tmo_c < 0) tmo_c = c;
      if (O_m_ack[0]) begin
        ack_c        = c;
        stb_at_abort = O_slv_stb;
      end
    end
    check("tmo_ack_cyc", 32'(ack_c), 32'd16);
    check("tmo_pulse_cyc", 32'(tmo_c), 32'd16);
    check("tmo_stb_cnt", 32'(stb_cnt), 32'd14);
    check("tmo_stb_low", 32'(stb_at_abort), 32'd0);
    @(posedge I_wb_clk);
    #1;
    set_req(0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge I_wb_clk);
    check("tmo_pulse_end", 32'(O_timeout), 32'd0);
    check("tmo_idle_grant", 32'(O_grant), 32'd0);
    @(posedge I_wb_clk);
    #1;
    ack_mode = 0;
`else
    for (int c = 1; c <= 100; c++) begin
      @(negedge I_wb_clk);
      if (O_slv_stb) stb_cnt++;
      if (|O_m_ack && ack_c < 0) ack_c = c;
      if (O_timeout) tmo_n++;
    end
    check("stall_no_ack", 32'(ack_c), 32'hFFFFFFFF);
    check("stall_no_timeout", 32'(tmo_n), 32'd0);
    check("stall_stb_cnt", 32'(stb_cnt), 32'd99);
    check("stall_grant", 32'(O_grant), 32'(onehot(0)));
    @(posedge I_wb_clk);
    #1;
    set_req(0, 1'b0, 1'b0, 1'b0, 8'h00);
    I_reset = 1'b1;
    @(posedge I_wb_clk);
    #1;
    I_reset = 1'b0;
    @(posedge I_wb_clk);
    #1;
    ack_mode = 0;
`endif

    repeat (2) @(posedge I_wb_clk);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 100000");
    $fatal(1, "watchdog");
  end

endmodule
